// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-stage branch resolution with a built-in branch history table of
//   2-bit saturating counters. Evaluates the branch condition on the register
//   operands, registers taken/mispredict/redirect one cycle later, provides a
//   combinational taken/not-taken prediction to fetch, and keeps saturating
//   branch and mispredict statistics.
//
// Ports
//   CLK, RESET        clock, asynchronous active-high reset
//   FETCH_PC          fetch PC; PREDICT_TAKEN is bit 1 of its BHT counter
//   EX_VALID, FLUSH   EX occupancy and kill (FLUSH wins)
//   BRANCH_SEL        [3] branch/jump, [2:0] funct3 (3'b010 for JAL/JALR)
//   DATA1, DATA2      rs1/rs2 operands
//   EX_PC             PC of the EX instruction (also selects the BHT entry)
//   EX_PRED_TAKEN     prediction carried down from fetch
//   BRANCH_TARGET     computed branch/jump target
//   RES_VALID, BRANCH_TAKEN, MISPREDICT, REDIRECT_PC   registered result
//   BRANCH_COUNT, MISPRED_COUNT                        saturating statistics
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [XLEN-1:0]  FETCH_PC,
  output logic             PREDICT_TAKEN,
  input  logic             EX_VALID,
  input  logic             FLUSH,
  input  logic [3:0]       BRANCH_SEL,
  input  logic [XLEN-1:0]  DATA1,
  input  logic [XLEN-1:0]  DATA2,
  input  logic [XLEN-1:0]  EX_PC,
  input  logic             EX_PRED_TAKEN,
  input  logic [XLEN-1:0]  BRANCH_TARGET,
  output logic             RES_VALID,
  output logic             BRANCH_TAKEN,
  output logic             MISPREDICT,
  output logic [XLEN-1:0]  REDIRECT_PC,
  output logic [CNT_W-1:0] BRANCH_COUNT,
  output logic [CNT_W-1:0] MISPRED_COUNT
);

  localparam int               IDX_W   = $clog2(BHT_ENTRIES);
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(3'd4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Branch condition by funct3; 3'b011 resolves as never taken.
  function automatic logic eval_cond(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic r;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = ($signed(a) <  $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a <  b);
      3'b111:  r = (a >= b);
      3'b010:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // 2-bit saturating counter step toward the actual outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic t);
    logic [1:0] n;
    if (t) begin
      n = (c == 2'b11) ? c : c + 2'b01;
    end else begin
      n = (c == 2'b00) ? c : c - 2'b01;
    end
    return n;
  endfunction

  logic [1:0]       bht_r [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             resolve_s;
  logic             taken_s;
  logic             cond_br_s;
  logic             mispred_s;
  logic [XLEN-1:0]  redirect_s;
  logic             res_valid_r;
  logic             taken_r;
  logic             mispred_r;
  logic [XLEN-1:0]  redirect_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispred_cnt_r;
  logic             unused_pc_bits_s;

  assign fetch_idx_s = FETCH_PC[IDX_W+1:2];
  assign ex_idx_s    = EX_PC[IDX_W+1:2];

  // Word-aligned PCs: low bits and bits above the index carry no information here.
  assign unused_pc_bits_s = ^{FETCH_PC[1:0], FETCH_PC[XLEN-1:IDX_W+2], EX_PC[1:0]};

  // Read-before-write: an update to the fetched entry shows only after the edge.
  assign PREDICT_TAKEN = bht_r[fetch_idx_s][1];

  // Condition evaluation and next-PC selection for the EX instruction.
  always_comb begin
    resolve_s  = EX_VALID & ~FLUSH & BRANCH_SEL[3];
    taken_s    = eval_cond(BRANCH_SEL[2:0], DATA1, DATA2);
    cond_br_s  = (BRANCH_SEL[2:0] != 3'b010) && (BRANCH_SEL[2:0] != 3'b011);
    mispred_s  = taken_s ^ EX_PRED_TAKEN;
    redirect_s = {XLEN{1'b0}};
    if (!mispred_s) begin
      redirect_s = {XLEN{1'b0}};
    end else if (taken_s) begin
      redirect_s = BRANCH_TARGET;
    end else begin
      redirect_s = EX_PC + PC_STEP;
    end
  end

  // Branch history table: counters reset to weak-not-taken, trained by conditional branches.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (resolve_s && cond_br_s) begin
      bht_r[ex_idx_s] <= bht_next(bht_r[ex_idx_s], taken_s);
    end
  end

  // Registered resolution result and saturating statistics.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      res_valid_r   <= 1'b0;
      taken_r       <= 1'b0;
      mispred_r     <= 1'b0;
      redirect_r    <= {XLEN{1'b0}};
      branch_cnt_r  <= {CNT_W{1'b0}};
      mispred_cnt_r <= {CNT_W{1'b0}};
    end else begin
      res_valid_r <= resolve_s;
      taken_r     <= resolve_s & taken_s;
      mispred_r   <= resolve_s & mispred_s;
      redirect_r  <= resolve_s ? redirect_s : {XLEN{1'b0}};
      if (resolve_s && (branch_cnt_r != CNT_MAX)) begin
        branch_cnt_r <= branch_cnt_r + CNT_ONE;
      end
      if (resolve_s && mispred_s && (mispred_cnt_r != CNT_MAX)) begin
        mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
      end
    end
  end

  assign RES_VALID     = res_valid_r;
  assign BRANCH_TAKEN  = taken_r;
  assign MISPREDICT    = mispred_r;
  assign REDIRECT_PC   = redirect_r;
  assign BRANCH_COUNT  = branch_cnt_r;
  assign MISPRED_COUNT = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int NENT = 64;
  localparam int CW   = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [XLEN-1:0] FETCH_PC = 32'h0;
  logic            PREDICT_TAKEN;
  logic            EX_VALID = 1'b0;
  logic            FLUSH = 1'b0;
  logic [3:0]      BRANCH_SEL = 4'h0;
  logic [XLEN-1:0] DATA1 = 32'h0, DATA2 = 32'h0, EX_PC = 32'h0, BRANCH_TARGET = 32'h0;
  logic            EX_PRED_TAKEN = 1'b0;
  logic            RES_VALID, BRANCH_TAKEN, MISPREDICT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic [CW-1:0]   BRANCH_COUNT, MISPRED_COUNT;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .FETCH_PC(FETCH_PC), .PREDICT_TAKEN(PREDICT_TAKEN),
    .EX_VALID(EX_VALID), .FLUSH(FLUSH), .BRANCH_SEL(BRANCH_SEL),
    .DATA1(DATA1), .DATA2(DATA2), .EX_PC(EX_PC), .EX_PRED_TAKEN(EX_PRED_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .RES_VALID(RES_VALID), .BRANCH_TAKEN(BRANCH_TAKEN),
    .MISPREDICT(MISPREDICT), .REDIRECT_PC(REDIRECT_PC),
    .BRANCH_COUNT(BRANCH_COUNT), .MISPRED_COUNT(MISPRED_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic            mis;
    logic [XLEN-1:0] redir;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] bht_m [NENT];
  int         br_cnt_m;
  int         mp_cnt_m;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return !($signed(a) < $signed(b));
      3'd6:    return a < b;
      3'd7:    return !(a < b);
      3'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) bht_m[i] = 2'b01;
    br_cnt_m = 0;
    mp_cnt_m = 0;
    sb_q.delete();
  endtask

  // Drive one EX cycle; the expected result is queued and checked after the edge.
  task automatic drive(input string tag, input logic v, input logic fl, input logic [3:0] sel,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] pc, input logic pr, input logic [XLEN-1:0] tgt);
    exp_t e, got_e;
    logic tk, res;
    int   idx;
    EX_VALID = v; FLUSH = fl; BRANCH_SEL = sel; DATA1 = d1; DATA2 = d2;
    EX_PC = pc; EX_PRED_TAKEN = pr; BRANCH_TARGET = tgt; FETCH_PC = pc;
    idx = int'(pc[7:2]);
    #1;
    check_eq({tag, "_pred_pre"}, {31'd0, PREDICT_TAKEN}, {31'd0, bht_m[idx][1]});
    res     = v && !fl && sel[3];
    tk      = model_taken(sel[2:0], d1, d2);
    e.valid = res;
    e.taken = res && tk;
    e.mis   = res && (tk != pr);
    e.redir = e.mis ? (tk ? tgt : pc + 32'd4) : 32'd0;
    sb_q.push_back(e);
    @(posedge CLK);
    if (res) begin
      if (br_cnt_m < 15) br_cnt_m++;
      if (e.mis && mp_cnt_m < 15) mp_cnt_m++;
      if (sel[2:0] != 3'b010 && sel[2:0] != 3'b011) begin
        if (tk && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'b01;
        else if (!tk && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'b01;
      end
    end
    #1;
    EX_VALID = 1'b0;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check_eq({tag, "_valid"},  {31'd0, RES_VALID},    {31'd0, got_e.valid});
      check_eq({tag, "_taken"},  {31'd0, BRANCH_TAKEN}, {31'd0, got_e.taken});
      check_eq({tag, "_mis"},    {31'd0, MISPREDICT},   {31'd0, got_e.mis});
      check_eq({tag, "_redir"},  REDIRECT_PC,           got_e.redir);
    end
    check_eq({tag, "_brcnt"},     {28'd0, BRANCH_COUNT},  32'(br_cnt_m));
    check_eq({tag, "_mpcnt"},     {28'd0, MISPRED_COUNT}, 32'(mp_cnt_m));
    check_eq({tag, "_pred_post"}, {31'd0, PREDICT_TAKEN}, {31'd0, bht_m[idx][1]});
  endtask

  initial begin
    model_reset();
    FETCH_PC = 32'h100;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_pred",  {31'd0, PREDICT_TAKEN}, 32'd0);
    check_eq("rst_valid", {31'd0, RES_VALID}, 32'd0);
    check_eq("rst_redir", REDIRECT_PC, 32'd0);
    check_eq("rst_brcnt", {28'd0, BRANCH_COUNT}, 32'd0);
    check_eq("rst_mpcnt", {28'd0, MISPRED_COUNT}, 32'd0);
    RESET = 1'b0;

    drive("beq",   1'b1, 1'b0, 4'b1000, 32'd5, 32'd5, 32'h100, 1'b0, 32'h140);
    drive("blt",   1'b1, 1'b0, 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'h308, 1'b0, 32'h80);
    drive("bltu",  1'b1, 1'b0, 4'b1110, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b1, 32'h999);
    for (int i = 0; i < 4; i++)
      drive("bne_t", 1'b1, 1'b0, 4'b1001, 32'd1, 32'd2, 32'h40C, bht_m[3][1], 32'h500);
    drive("bne_nt", 1'b1, 1'b0, 4'b1001, 32'd7, 32'd7, 32'h40C, bht_m[3][1], 32'h500);
    drive("jal",   1'b1, 1'b0, 4'b1010, 32'd0, 32'd0, 32'h410, 1'b1, 32'h800);
    drive("jal_fl", 1'b1, 1'b1, 4'b1010, 32'd0, 32'd0, 32'h410, 1'b1, 32'h800);
    drive("nonbr", 1'b1, 1'b0, 4'b0000, 32'd3, 32'd3, 32'h414, 1'b0, 32'h900);
    drive("f011",  1'b1, 1'b0, 4'b1011, 32'd3, 32'd3, 32'h418, 1'b1, 32'h900);
    drive("bge",   1'b1, 1'b0, 4'b1101, 32'd1, 32'h8000_0000, 32'h41C, 1'b0, 32'hA00);
    drive("bgeu",  1'b1, 1'b0, 4'b1111, 32'd1, 32'h8000_0000, 32'h420, 1'b1, 32'hA00);
    drive("wrap",  1'b1, 1'b0, 4'b1000, 32'd1, 32'd2, 32'hFFFF_FFFC, 1'b1, 32'hB00);
    for (int i = 0; i < 20; i++)
      drive("sat", 1'b1, 1'b0, 4'b1000, 32'(i), 32'(i), 32'h600 + 32'(i * 4), 1'b0, 32'hC00);
    check_eq("mp_sat", {28'd0, MISPRED_COUNT}, 32'd15);
    check_eq("br_sat", {28'd0, BRANCH_COUNT}, 32'd15);

    // Mid-operation reset: a mispredicting branch is in EX when RESET rises.
    EX_VALID = 1'b1; FLUSH = 1'b0; BRANCH_SEL = 4'b1000; DATA1 = 32'd9; DATA2 = 32'd9;
    EX_PC = 32'h100; EX_PRED_TAKEN = 1'b0; BRANCH_TARGET = 32'hD00; FETCH_PC = 32'h100;
    #2;
    RESET = 1'b1;
    #1;
    check_eq("arst_brcnt", {28'd0, BRANCH_COUNT}, 32'd0);
    check_eq("arst_mpcnt", {28'd0, MISPRED_COUNT}, 32'd0);
    check_eq("arst_valid", {31'd0, RES_VALID}, 32'd0);
    check_eq("arst_pred",  {31'd0, PREDICT_TAKEN}, 32'd0);
    @(posedge CLK);
    #1;
    check_eq("arst_hold_valid", {31'd0, RES_VALID}, 32'd0);
    check_eq("arst_hold_mis",   {31'd0, MISPREDICT}, 32'd0);
    RESET = 1'b0;
    model_reset();
    drive("post_rst", 1'b1, 1'b0, 4'b1000, 32'd9, 32'd9, 32'h100, 1'b0, 32'hD00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
